// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral register bank: synchronised SCLK/COPI/nCS, framed R/W + address + data,
// per-register write strobes, CIPO read-back and frame-error pulses.
module spi_reg_bank #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0]  CNT_HDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_X    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   hdr_sr;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_sr;
  logic [DATA_W-1:0]   rd_sr;

  logic                sclk_s, copi_s, ncs_s;
  logic                sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic [ADDR_W:0]     hdr_next;
  logic                addr_ok;
  logic [DATA_W-1:0]   rd_sel;

  // Input synchronisers plus edge-detect delay flops; nCS idles high so its chain resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  assign hdr_next  = {hdr_sr, copi_s};
  assign addr_ok   = {1'b0, addr_q} < NUM_REGS_X;

  // Read-back source for the address completing on this edge; out-of-range reads return 0
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) rd_sel = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hdr_sr    <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      CIPO      <= 1'b0;
      cipo_oe   <= 1'b0;
      regs_flat <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      cipo_oe   <= ~ncs_s;
      if (ncs_rise) begin
        // End of frame has priority over a coincident SCLK edge; frames with no bits are ignored
        state <= IDLE;
        cnt   <= '0;
        CIPO  <= 1'b0;
        if (cnt != '0) begin
          if (cnt != CNT_FULL || !addr_ok) begin
            frame_err <= 1'b1;
          end else if (rw_q) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (addr_q == ADDR_W'(i)) begin
                regs_flat[i*DATA_W +: DATA_W] <= data_sr;
                wr_strobe[i]                  <= 1'b1;
              end
            end
          end
        end
      end else if (ncs_fall) begin
        state   <= HDR;
        cnt     <= '0;
        hdr_sr  <= '0;
        rw_q    <= 1'b0;
        addr_q  <= '0;
        data_sr <= '0;
        rd_sr   <= '0;
        CIPO    <= 1'b0;
      end else if (sclk_rise && state != IDLE) begin
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        case (state)
          HDR: begin
            hdr_sr <= hdr_next[ADDR_W-1:0];
            if (cnt == CNT_HDR_LAST) begin
              state  <= DATA;
              rw_q   <= hdr_next[ADDR_W];
              addr_q <= hdr_next[ADDR_W-1:0];
              rd_sr  <= rd_sel;
            end
          end
          DATA: begin
            if (rw_q) data_sr <= {data_sr[DATA_W-2:0], copi_s};
            if (cnt == CNT_DATA_LAST) begin
              state <= DONE;
              CIPO  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (sclk_fall && state == DATA && !rw_q) begin
        // Read data leaves MSB first, one bit per SCLK falling edge
        CIPO  <= rd_sr[DATA_W-1];
        rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule
